// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter
// Sits between the two clock-crossing frame FIFOs and the DDR3 MIG native
// user interface, all in the 100 MHz ui_clk domain. Write bursts drain
// BURST_LEN 128-bit words from the write FIFO into DDR3. Read bursts refill
// the read FIFO from DDR3. Each direction walks its own circular frame buffer
// and restarts at its base address when its load pulse arrives.
//
// Ports
//   clk_100, rst                 user clock, synchronous active-high reset
//   init_calib_complete          MIG calibration done
//   fifo_init_ok                 both FIFOs out of reset; gates new bursts
//   wr_load, rd_load             single-cycle address restart pulses
//   wfifo_rcount/dout/rden       write-FIFO read side (first-word-fall-through)
//   rfifo_wcount/din/wren        read-FIFO write side
//   app_*                        MIG command, write-data and read-data ports
//   busy                         high while a WRITE or READ burst is active
module ddr3_rw_arbiter #(
    parameter int          BURST_LEN   = 64,
    parameter int          FRAME_BEATS = 98304,
    parameter logic [27:0] WR_BASE     = 28'h0000000,
    parameter logic [27:0] RD_BASE     = 28'h0000000,
    parameter int          ADDR_STEP   = 8,
    parameter int          RD_THRESH   = 512
) (
    input  logic         clk_100,
    input  logic         rst,
    input  logic         init_calib_complete,
    input  logic         fifo_init_ok,
    input  logic         wr_load,
    input  logic         rd_load,
    input  logic [10:0]  wfifo_rcount,
    input  logic [127:0] wfifo_dout,
    output logic         wfifo_rden,
    input  logic [10:0]  rfifo_wcount,
    output logic [127:0] rfifo_din,
    output logic         rfifo_wren,
    output logic [27:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    output logic [15:0]  app_wdf_mask,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid,
    output logic         busy
);

    // state   | meaning
    // S_INIT  | waiting for MIG calibration and FIFO reset release
    // S_IDLE  | arbitrating between write and read requests
    // S_WRITE | issuing a write burst (commands and data independently)
    // S_READ  | issuing read commands and counting returned beats
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE, S_READ} state_t;

    localparam int          CW      = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BL_CNT = CW'(BURST_LEN);
    localparam logic [10:0] BL_LVL  = 11'(BURST_LEN);
    localparam logic [10:0] RD_LVL  = 11'(RD_THRESH);
    localparam logic [27:0] STEP    = 28'(ADDR_STEP);
    localparam logic [27:0] SPAN    = 28'((FRAME_BEATS - 1) * ADDR_STEP);
    localparam logic [27:0] WR_LAST = WR_BASE + SPAN;
    localparam logic [27:0] RD_LAST = RD_BASE + SPAN;

    state_t          state_q, state_d;
    logic [CW-1:0]   cmd_cnt_q, cmd_cnt_d;
    logic [CW-1:0]   dat_cnt_q, dat_cnt_d;
    logic [CW-1:0]   ret_cnt_q, ret_cnt_d;
    logic [27:0]     wr_addr_q, wr_addr_d;
    logic [27:0]     rd_addr_q, rd_addr_d;
    logic            pending_wr_q, pending_wr_d;
    logic            pending_rd_q, pending_rd_d;
    logic            last_was_write_q, last_was_write_d;

    logic in_wr, in_rd, cmd_acc, wr_done, rd_done, wr_req, rd_req;
    logic pend_wr, pend_rd;

    // All command/data qualifiers decode from registered state; only the
    // FIFO pop and push see the MIG handshake inputs combinationally.
    assign in_wr        = (state_q == S_WRITE);
    assign in_rd        = (state_q == S_READ);
    assign busy         = in_wr || in_rd;
    assign app_en       = busy && (cmd_cnt_q < BL_CNT);
    assign app_cmd      = in_rd ? 3'b001 : 3'b000;
    assign app_addr     = in_rd ? rd_addr_q : wr_addr_q;
    assign app_wdf_wren = in_wr && (dat_cnt_q < BL_CNT);
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = wfifo_dout;
    assign app_wdf_mask = 16'h0000;
    assign wfifo_rden   = app_wdf_wren && app_wdf_rdy;
    assign rfifo_din    = app_rd_data;
    assign rfifo_wren   = app_rd_data_valid;

    assign cmd_acc = app_en && app_rdy;
    assign wr_done = in_wr && (cmd_cnt_q == BL_CNT) && (dat_cnt_q == BL_CNT);
    assign rd_done = in_rd && (cmd_cnt_q == BL_CNT) && (ret_cnt_q == BL_CNT);
    assign wr_req  = (wfifo_rcount >= BL_LVL);
    assign rd_req  = (rfifo_wcount < RD_LVL);
    assign pend_wr = pending_wr_q || wr_load;
    assign pend_rd = pending_rd_q || rd_load;

    always_comb begin
        state_d          = state_q;
        cmd_cnt_d        = cmd_cnt_q;
        dat_cnt_d        = dat_cnt_q;
        ret_cnt_d        = ret_cnt_q;
        wr_addr_d        = wr_addr_q;
        rd_addr_d        = rd_addr_q;
        last_was_write_d = last_was_write_q;

        case (state_q)
            S_INIT: begin
                if (init_calib_complete && fifo_init_ok) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (fifo_init_ok) begin
                    // Round-robin only matters when both directions want service.
                    if (wr_req && (!rd_req || !last_was_write_q)) begin
                        state_d          = S_WRITE;
                        last_was_write_d = 1'b1;
                    end else if (rd_req) begin
                        state_d          = S_READ;
                        last_was_write_d = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                if (cmd_acc) begin
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    wr_addr_d = (wr_addr_q == WR_LAST) ? WR_BASE : wr_addr_q + STEP;
                end
                if (wfifo_rden) dat_cnt_d = dat_cnt_q + 1'b1;
                if (wr_done) begin
                    state_d   = S_IDLE;
                    cmd_cnt_d = '0;
                    dat_cnt_d = '0;
                end
            end
            S_READ: begin
                if (cmd_acc) begin
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    rd_addr_d = (rd_addr_q == RD_LAST) ? RD_BASE : rd_addr_q + STEP;
                end
                if (app_rd_data_valid) ret_cnt_d = ret_cnt_q + 1'b1;
                if (rd_done) begin
                    state_d   = S_IDLE;
                    cmd_cnt_d = '0;
                    ret_cnt_d = '0;
                end
            end
            default: state_d = S_INIT;
        endcase

        // A load never lands mid-burst: it waits for the exit cycle, where no
        // command can be accepted, so the reload cannot collide with an advance.
        pending_wr_d = pend_wr;
        if (pend_wr && (!in_wr || wr_done)) begin
            wr_addr_d    = WR_BASE;
            pending_wr_d = 1'b0;
        end
        pending_rd_d = pend_rd;
        if (pend_rd && (!in_rd || rd_done)) begin
            rd_addr_d    = RD_BASE;
            pending_rd_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state_q          <= S_INIT;
            cmd_cnt_q        <= '0;
            dat_cnt_q        <= '0;
            ret_cnt_q        <= '0;
            wr_addr_q        <= WR_BASE;
            rd_addr_q        <= RD_BASE;
            pending_wr_q     <= 1'b0;
            pending_rd_q     <= 1'b0;
            last_was_write_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cmd_cnt_q        <= cmd_cnt_d;
            dat_cnt_q        <= dat_cnt_d;
            ret_cnt_q        <= ret_cnt_d;
            wr_addr_q        <= wr_addr_d;
            rd_addr_q        <= rd_addr_d;
            pending_wr_q     <= pending_wr_d;
            pending_rd_q     <= pending_rd_d;
            last_was_write_q <= last_was_write_d;
        end
    end

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench for ddr3_rw_arbiter. Scenario code pushes the expected
// command stream and write data before enabling each burst. A monitor on the
// falling edge pops and compares every accepted command and write beat, and
// checks per-burst beat counts and the FIFO push/pop mirrors. A small frame
// (FRAME_BEATS = 160) keeps the address wrap reachable in a short run.
module tb_ddr3_rw_arbiter;

    localparam int          BL   = 64;
    localparam int          FB   = 160;
    localparam int          STEP = 8;
    localparam logic [27:0] WRB  = 28'h0001000;
    localparam logic [27:0] RDB  = 28'h0800000;
    localparam logic [127:0] STRAY = 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF;

    logic         clk_100 = 1'b0;
    logic         rst;
    logic         init_calib_complete, fifo_init_ok, wr_load, rd_load;
    logic [10:0]  wfifo_rcount, rfifo_wcount;
    logic [127:0] wfifo_dout, rfifo_din, app_wdf_data, app_rd_data;
    logic         wfifo_rden, rfifo_wren;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [15:0]  app_wdf_mask;
    logic         app_rd_data_valid, busy;

    always #5 clk_100 = ~clk_100;

    ddr3_rw_arbiter #(
        .BURST_LEN(BL), .FRAME_BEATS(FB), .WR_BASE(WRB), .RD_BASE(RDB),
        .ADDR_STEP(STEP), .RD_THRESH(512)
    ) dut (
        .clk_100(clk_100), .rst(rst),
        .init_calib_complete(init_calib_complete), .fifo_init_ok(fifo_init_ok),
        .wr_load(wr_load), .rd_load(rd_load),
        .wfifo_rcount(wfifo_rcount), .wfifo_dout(wfifo_dout), .wfifo_rden(wfifo_rden),
        .rfifo_wcount(rfifo_wcount), .rfifo_din(rfifo_din), .rfifo_wren(rfifo_wren),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    logic [30:0]  exp_cmd[$];
    logic [127:0] exp_wdat[$];
    logic [27:0]  rd_pend[$];

    int pop_cnt = 0, exp_pop = 0, wr_idx = 0, rd_idx = 0;
    int burst_cmds = 0, burst_dats = 0, burst_rets = 0, burst_cycles = 0;
    int last_len = 0, n_rises = 0, n_falls = 0;
    bit burst_is_wr = 1'b0, busy_prev = 1'b0, bp_en = 1'b0, force_valid = 1'b0;

    function automatic logic [127:0] wdata(input int k);
        return {4{32'hC0DE_0000 + 32'(k)}};
    endfunction

    function automatic logic [127:0] rdata(input logic [27:0] a);
        return {4{4'hD, a}};
    endfunction

    assign wfifo_dout = wdata(pop_cnt);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Expected burst: addresses follow the frame index modulo FB.
    task automatic push_burst(input bit is_wr);
        for (int i = 0; i < BL; i++) begin
            if (is_wr) begin
                exp_cmd.push_back({3'b000, WRB + 28'(wr_idx * STEP)});
                exp_wdat.push_back(wdata(exp_pop));
                exp_pop++;
                wr_idx = (wr_idx + 1) % FB;
            end else begin
                exp_cmd.push_back({3'b001, RDB + 28'(rd_idx * STEP)});
                rd_idx = (rd_idx + 1) % FB;
            end
        end
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (n_rises < target && n < 3000) begin @(negedge clk_100); n++; end
        check("burst_start_timeout", 128'(n_rises >= target), 128'd1);
    endtask

    task automatic wait_falls(input int target);
        int n = 0;
        while (n_falls < target && n < 3000) begin @(negedge clk_100); n++; end
        check("burst_end_timeout", 128'(n_falls >= target), 128'd1);
    endtask

    task automatic wait_cmds(input int target);
        int n = 0;
        while (!(busy && burst_cmds >= target) && n < 3000) begin @(negedge clk_100); n++; end
        check("cmd_count_timeout", 128'(burst_cmds >= target), 128'd1);
    endtask

    // Monitor: everything sampled here is what the DUT sees at the next rising edge.
    initial forever begin
        @(negedge clk_100);
        if (busy && !busy_prev) begin
            n_rises++;
            burst_cmds = 0; burst_dats = 0; burst_rets = 0; burst_cycles = 0;
        end
        if (busy) burst_cycles++;
        if (app_en) check("en_outside_burst", 128'(busy), 128'd1);
        if (app_en && app_rdy) begin
            if (exp_cmd.size() == 0) begin
                tests++; fails++;
                $display("FAIL cmd_unexpected: got cmd %b addr %h, required none", app_cmd, app_addr);
            end else begin
                check("cmd", 128'({app_cmd, app_addr}), 128'(exp_cmd.pop_front()));
            end
            if (app_cmd == 3'b001) rd_pend.push_back(app_addr);
            burst_is_wr = (app_cmd == 3'b000);
            burst_cmds++;
        end
        if (app_wdf_wren || wfifo_rden)
            check("wfifo_rden", 128'(wfifo_rden), 128'(app_wdf_wren && app_wdf_rdy));
        if (app_wdf_wren && app_wdf_rdy) begin
            if (exp_wdat.size() == 0) begin
                tests++; fails++;
                $display("FAIL wdata_unexpected: got %h, required none", app_wdf_data);
            end else begin
                check("wdata", app_wdf_data, exp_wdat.pop_front());
            end
            check("wdf_end", 128'(app_wdf_end), 128'd1);
            check("wdf_mask", 128'(app_wdf_mask), 128'd0);
            burst_dats++;
        end
        if (wfifo_rden) pop_cnt++;
        if (app_rd_data_valid || rfifo_wren) begin
            check("rfifo_wren", 128'(rfifo_wren), 128'(app_rd_data_valid));
            check("rfifo_din", rfifo_din, app_rd_data);
        end
        if (app_rd_data_valid && busy) burst_rets++;
        if (!busy && busy_prev) begin
            n_falls++;
            last_len = burst_cycles;
            check("burst_cmds", 128'(burst_cmds), 128'(BL));
            if (burst_is_wr) check("burst_wbeats", 128'(burst_dats), 128'(BL));
            else             check("burst_rbeats", 128'(burst_rets), 128'(BL));
        end
        busy_prev = busy;
    end

    // MIG model: handshake back-pressure and read returns, driven 2 ns after the edge.
    initial begin
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
        forever begin
            @(posedge clk_100); #2;
            if (!bp_en) begin
                app_rdy = 1'b1; app_wdf_rdy = 1'b1;
            end else begin
                bit r1, r2;
                r1 = ($urandom_range(0, 9) >= 3);
                r2 = ($urandom_range(0, 9) >= 3);
                if (busy && app_cmd == 3'b000) begin
                    // Data leads commands by 1..10 beats during write bursts.
                    app_rdy     = r1 && (burst_cmds < burst_dats || burst_dats >= BL);
                    app_wdf_rdy = r2 && (burst_dats < burst_cmds + 10);
                end else begin
                    app_rdy = r1; app_wdf_rdy = r2;
                end
            end
            if (force_valid) begin
                app_rd_data_valid = 1'b1; app_rd_data = STRAY;
            end else if (rd_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                app_rd_data_valid = 1'b1; app_rd_data = rdata(rd_pend.pop_front());
            end else begin
                app_rd_data_valid = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; init_calib_complete = 1'b0; fifo_init_ok = 1'b0;
        wr_load = 1'b0; rd_load = 1'b0; wfifo_rcount = 11'd0; rfifo_wcount = 11'd600;
        force_valid = 1'b1;
        repeat (3) @(posedge clk_100);
        @(negedge clk_100);
        check("rst_app_en", 128'(app_en), 128'd0);
        check("rst_wdf_wren", 128'(app_wdf_wren), 128'd0);
        check("rst_wdf_end", 128'(app_wdf_end), 128'd0);
        check("rst_rden", 128'(wfifo_rden), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_rfifo_wren", 128'(rfifo_wren), 128'd1);

        // Single write burst straight after reset.
        @(posedge clk_100); #1;
        force_valid = 1'b0; init_calib_complete = 1'b1; fifo_init_ok = 1'b1;
        wfifo_rcount = 11'd64;
        push_burst(1'b1);
        @(posedge clk_100); #1 rst = 1'b0;
        @(negedge clk_100); check("lat_init", 128'(app_en), 128'd0);
        @(negedge clk_100); check("lat_idle", 128'(app_en), 128'd0);
        @(negedge clk_100); check("lat_first_en", 128'(app_en), 128'd1);
        wait_rises(1);
        wfifo_rcount = 11'd0;
        wait_falls(1);
        check("write_burst_cycles", 128'(last_len), 128'(BL + 1));
        check("s1_queue", 128'(exp_cmd.size()), 128'd0);

        // Both requests true: READ, WRITE, READ by round-robin.
        push_burst(1'b0); push_burst(1'b1); push_burst(1'b0);
        @(posedge clk_100); #1 wfifo_rcount = 11'd64; rfifo_wcount = 11'd0;
        wait_rises(4);
        wfifo_rcount = 11'd0; rfifo_wcount = 11'd600;
        wait_falls(4);
        check("s2_queue", 128'(exp_cmd.size()), 128'd0);

        // Back-pressure, both bursts cross the frame wrap.
        bp_en = 1'b1;
        push_burst(1'b1);
        wfifo_rcount = 11'd64;
        wait_rises(5);
        wfifo_rcount = 11'd0;
        wait_falls(5);
        push_burst(1'b0);
        rfifo_wcount = 11'd0;
        wait_rises(6);
        rfifo_wcount = 11'd600;
        wait_falls(6);
        bp_en = 1'b0;
        check("s3_queue", 128'(exp_cmd.size()), 128'd0);

        // rd_load mid-burst: current burst runs on, the next one starts at base.
        push_burst(1'b0);
        rd_idx = 0;
        push_burst(1'b0);
        rfifo_wcount = 11'd0;
        wait_rises(7);
        wait_cmds(20);
        @(posedge clk_100); #1 rd_load = 1'b1;
        @(posedge clk_100); #1 rd_load = 1'b0;
        wait_rises(8);
        rfifo_wcount = 11'd600;
        wait_falls(8);

        // wr_load while idle: next write starts at base.
        @(posedge clk_100); #1 wr_load = 1'b1;
        @(posedge clk_100); #1 wr_load = 1'b0;
        wr_idx = 0;
        push_burst(1'b1);
        wfifo_rcount = 11'd64;
        wait_rises(9);
        wfifo_rcount = 11'd0;
        wait_falls(9);
        check("s4_queue", 128'(exp_cmd.size()), 128'd0);

        // fifo_init_ok low blocks new bursts, then a mid-burst drop is ignored.
        @(posedge clk_100); #1;
        fifo_init_ok = 1'b0; wfifo_rcount = 11'd64; rfifo_wcount = 11'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_100);
            check("blocked_en", 128'(app_en), 128'd0);
            check("blocked_busy", 128'(busy), 128'd0);
        end
        push_burst(1'b0);
        @(posedge clk_100); #1 fifo_init_ok = 1'b1;
        @(negedge clk_100); check("resume_c0", 128'(app_en), 128'd0);
        @(negedge clk_100); check("resume_c1", 128'(app_en), 128'd1);
        check("resume_cmd", 128'(app_cmd), 128'd1);
        wait_rises(10);
        wfifo_rcount = 11'd0; rfifo_wcount = 11'd600;
        wait_cmds(10);
        fifo_init_ok = 1'b0;
        wait_falls(10);
        check("s5_queue", 128'(exp_cmd.size()), 128'd0);
        @(posedge clk_100); #1 fifo_init_ok = 1'b1;

        // Stray read valid while idle is still pushed.
        @(posedge clk_100); #1 force_valid = 1'b1;
        @(negedge clk_100);
        check("stray_wren", 128'(rfifo_wren), 128'd1);
        check("stray_din", rfifo_din, STRAY);
        check("stray_idle", 128'(busy), 128'd0);
        @(posedge clk_100); #1 force_valid = 1'b0;

        repeat (5) @(negedge clk_100);
        check("final_cmd_queue", 128'(exp_cmd.size()), 128'd0);
        check("final_wdat_queue", 128'(exp_wdat.size()), 128'd0);
        check("final_rd_pending", 128'(rd_pend.size()), 128'd0);
        check("final_pops", 128'(pop_cnt), 128'(exp_pop));
        check("final_busy", 128'(busy), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
